// File: rtl/umi_pack_buf.sv
// umi_pack_buf: packs decoded UMI transaction fields into one 256-bit UMI packet.
// Latency: 1 cycle from input acceptance to out_valid. Sustains 1 packet/cycle.
// Backpressure: 2-entry skid buffer. in_ready comes straight from state flops, with no out_ready path.
// Optional: define UMI_PACK_BUF_STATS_EN to add the pkt_count output-transfer counter.
module umi_pack_buf #(
    parameter int AW = 64,
    parameter int UW = 256
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            write,
    input  logic [6:0]      command,
    input  logic [3:0]      size,
    input  logic [19:0]     options,
    input  logic [AW-1:0]   dstaddr,
    input  logic [AW-1:0]   srcaddr,
    input  logic [4*AW-1:0] data,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef UMI_PACK_BUF_STATS_EN
    output logic [31:0]     pkt_count,
`endif
    output logic [UW-1:0]   out_packet
);

    // Packet layout, MSB first. This is the inverse of the UMI unpack field mapping.
    typedef struct packed {
        logic [31:0] dst_hi;
        logic [31:0] src_hi;
        logic [31:0] data_w2;
        logic [31:0] data_w1;
        logic [31:0] data_w0;
        logic [31:0] src_lo;
        logic [31:0] dst_lo;
        logic [19:0] options;
        logic [3:0]  size;
        logic [6:0]  command;
        logic        write;
    } pkt_t;

    // State bit 0 is out_valid. State bit 1 marks the skid entry as full, so in_ready is low.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;
    pkt_t   pkt_in;
    pkt_t   oreg;
    pkt_t   sreg;
    logic   in_xfer;
    logic   out_xfer;
    logic   load_in;
    logic   load_skid;
    logic   load_from_skid;

    generate
        if (AW == 64 && UW == 256) begin : g_pack
            // Combinational field packing ahead of the buffer
            always_comb begin
                pkt_in         = '0;
                pkt_in.write   = write;
                pkt_in.command = command;
                pkt_in.size    = size;
                pkt_in.options = options;
                pkt_in.dst_lo  = dstaddr[31:0];
                pkt_in.src_lo  = srcaddr[31:0];
                pkt_in.data_w0 = data[31:0];
                pkt_in.data_w1 = data[63:32];
                pkt_in.data_w2 = data[95:64];
                pkt_in.src_hi  = srcaddr[63:32];
                pkt_in.dst_hi  = dstaddr[63:32];
            end
            // data[255:96] is dropped on purpose. On unpack, those positions alias header fields.
            logic unused_data;
            assign unused_data = ^data[4*AW-1:96];
        end else begin : g_bad
            assign pkt_in = '0;
            $error("umi_pack_buf: only AW=64 and UW=256 are supported");
        end
    endgenerate

    assign in_xfer  = in_valid & ~state[1];
    assign out_xfer = state[0] & out_ready;

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= ST_EMPTY;
        else         state <= state_nxt;
    end

    // Next-state logic for the 0/1/2 occupancy tracker
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (in_xfer) state_nxt = ST_ONE;
            ST_ONE: begin
                if (in_xfer && !out_xfer)      state_nxt = ST_TWO;
                else if (!in_xfer && out_xfer) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (out_xfer) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake outputs decode flops only. Datapath load strobes follow the transfer conditions.
    always_comb begin
        out_valid      = state[0];
        in_ready       = ~state[1];
        load_in        = in_xfer && (state == ST_EMPTY || (state == ST_ONE && out_xfer));
        load_skid      = in_xfer && state == ST_ONE && !out_xfer;
        load_from_skid = out_xfer && state == ST_TWO;
    end

    // Output register. It is reloaded only on the cycle its current packet leaves or when it is empty.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)             oreg <= '0;
        else if (load_in)        oreg <= pkt_in;
        else if (load_from_skid) oreg <= sreg;
    end

    // Skid register. It catches the packet accepted while the output register is stalled.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)        sreg <= '0;
        else if (load_skid) sreg <= pkt_in;
    end

    assign out_packet = oreg;

`ifdef UMI_PACK_BUF_STATS_EN
    // Count output transfers. The counter wraps naturally at 2^32.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)       pkt_count <= '0;
        else if (out_xfer) pkt_count <= pkt_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_umi_pack_buf.sv
// tb_umi_pack_buf: directed and random checks of umi_pack_buf field packing and skid buffering.
// Inputs change 1 time unit after each rising edge. Outputs are checked in that same window.
// A queue model of the buffer contents predicts in_ready, out_valid and out_packet each cycle.
module tb_umi_pack_buf;

    typedef struct packed {
        logic         w;
        logic [6:0]   cmd;
        logic [3:0]   sz;
        logic [19:0]  opt;
        logic [63:0]  dst;
        logic [63:0]  src;
        logic [255:0] dat;
    } fld_t;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         write = 1'b0;
    logic [6:0]   command = '0;
    logic [3:0]   size = '0;
    logic [19:0]  options = '0;
    logic [63:0]  dstaddr = '0;
    logic [63:0]  srcaddr = '0;
    logic [255:0] data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] out_packet;
`ifdef UMI_PACK_BUF_STATS_EN
    logic [31:0]  pkt_count;
`endif

    umi_pack_buf #(.AW(64), .UW(256)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .write      (write),
        .command    (command),
        .size       (size),
        .options    (options),
        .dstaddr    (dstaddr),
        .srcaddr    (srcaddr),
        .data       (data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef UMI_PACK_BUF_STATS_EN
        .pkt_count  (pkt_count),
`endif
        .out_packet (out_packet)
    );

    always #5 clk = ~clk;

    int           nchk = 0;
    int           nerr = 0;
    int           nout = 0;
    logic [255:0] exp_q[$];
    bit           stall_prev = 1'b0;
    logic [255:0] pkt_prev = '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference packing written straight from the UMI field map
    function automatic logic [255:0] pack(input fld_t f);
        return {f.dst[63:32], f.src[63:32], f.dat[95:64], f.dat[63:32], f.dat[31:0],
                f.src[31:0], f.dst[31:0], f.opt, f.sz, f.cmd, f.w};
    endfunction

    function automatic fld_t unpack(input logic [255:0] p);
        fld_t f;
        f       = '0;
        f.w     = p[0];
        f.cmd   = p[7:1];
        f.sz    = p[11:8];
        f.opt   = p[31:12];
        f.dst   = {p[255:224], p[63:32]};
        f.src   = {p[223:192], p[95:64]};
        f.dat   = {160'b0, p[191:160], p[159:128], p[127:96]};
        return f;
    endfunction

    function automatic fld_t rnd_fld();
        fld_t        f;
        logic [31:0] r;
        r     = $urandom;
        f.w   = r[0];
        f.cmd = r[7:1];
        f.sz  = r[11:8];
        f.opt = r[31:12];
        f.dst = {$urandom, $urandom};
        f.src = {$urandom, $urandom};
        f.dat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return f;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model, then clock.
    task automatic step(input bit iv, input fld_t f, input bit ordy, output bit acc);
        in_valid  = iv;
        write     = f.w;
        command   = f.cmd;
        size      = f.sz;
        options   = f.opt;
        dstaddr   = f.dst;
        srcaddr   = f.src;
        data      = f.dat;
        out_ready = ordy;
        chk("in_ready", 256'(in_ready), 256'(exp_q.size() < 2));
        chk("out_valid", 256'(out_valid), 256'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk("out_packet", out_packet, exp_q[0]);
        if (stall_prev) chk("hold_stable", out_packet, pkt_prev);
        stall_prev = (exp_q.size() > 0) && !ordy;
        pkt_prev   = out_packet;
        acc = iv && (exp_q.size() < 2);
        if (ordy && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            nout++;
        end
        if (acc) exp_q.push_back(pack(f));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fld_t f1, pa, pb, pc, cur;
        fld_t idle;
        bit   acc;
        bit   pending;
        int   n0;
        int   accepted;
        int   budget;

        idle = '0;
        #12;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_out_packet", out_packet, 256'(0));
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // Field mapping. Junk in data[255:96] must not reach the packet.
        f1.w   = 1'b1;
        f1.cmd = 7'h05;
        f1.sz  = 4'h3;
        f1.opt = 20'hABCDE;
        f1.dst = 64'h1111_2222_3333_4444;
        f1.src = 64'h5555_6666_7777_8888;
        f1.dat = {160'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 96'h0000CCCC_0000BBBB_0000AAAA};
        step(1'b1, f1, 1'b1, acc);
        chk("map_valid", 256'(out_valid), 256'(1));
        chk("map_w0", 256'(out_packet[31:0]), 256'(32'hABCDE30B));
        chk("map_w1", 256'(out_packet[63:32]), 256'(32'h33334444));
        chk("map_w2", 256'(out_packet[95:64]), 256'(32'h77778888));
        chk("map_w3", 256'(out_packet[127:96]), 256'(32'h0000AAAA));
        chk("map_w4", 256'(out_packet[159:128]), 256'(32'h0000BBBB));
        chk("map_w5", 256'(out_packet[191:160]), 256'(32'h0000CCCC));
        chk("map_w6", 256'(out_packet[223:192]), 256'(32'h55556666));
        chk("map_w7", 256'(out_packet[255:224]), 256'(32'h11112222));
        f1.dat[255:96] = '0;
        chk("map_unpack", 256'(unpack(out_packet)), 256'(f1));
        step(1'b0, idle, 1'b1, acc);

        // Streaming: 16 back-to-back packets
        n0 = nout;
        for (int i = 0; i < 16; i++) step(1'b1, rnd_fld(), 1'b1, acc);
        step(1'b0, idle, 1'b1, acc);
        chk("stream_count", 256'(nout - n0), 256'(16));

        // Backpressure: 2 packets fit, then the third is refused
        n0 = nout;
        pa = rnd_fld();
        pb = rnd_fld();
        pc = rnd_fld();
        step(1'b1, pa, 1'b0, acc);
        step(1'b1, pb, 1'b0, acc);
        chk("bp_in_ready", 256'(in_ready), 256'(0));
        chk("bp_hold", out_packet, pack(pa));
        step(1'b1, pc, 1'b0, acc);
        chk("bp_reject", 256'(acc), 256'(0));
        acc = 1'b0;
        for (int i = 0; i < 5 && !acc; i++) step(1'b1, pc, 1'b1, acc);
        chk("bp_p3_accepted", 256'(acc), 256'(1));
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) step(1'b0, idle, 1'b1, acc);
        chk("bp_delivered", 256'(nout - n0), 256'(3));
        chk("bp_drained", 256'(exp_q.size()), 256'(0));

        // Random valid/ready traffic. Fields are held while a packet waits for acceptance.
        accepted = 0;
        budget   = 0;
        pending  = 1'b0;
        cur      = idle;
        while (accepted < 10000 && budget < 60000) begin
            if (!pending) begin
                cur     = rnd_fld();
                pending = ($urandom_range(1, 0) == 1);
            end
            step(pending, cur, ($urandom_range(1, 0) == 1), acc);
            if (acc) begin
                accepted++;
                pending = 1'b0;
            end
            budget++;
        end
        chk("rand_accepted", 256'(accepted), 256'(10000));
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) step(1'b0, idle, 1'b1, acc);
        chk("rand_drained", 256'(exp_q.size()), 256'(0));

        // Asynchronous reset while both registers are full
        step(1'b1, pa, 1'b0, acc);
        step(1'b1, pb, 1'b0, acc);
        chk("two_in_ready", 256'(in_ready), 256'(0));
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_out_valid", 256'(out_valid), 256'(0));
        chk("arst_in_ready", 256'(in_ready), 256'(1));
        chk("arst_out_packet", out_packet, 256'(0));
        exp_q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        step(1'b1, pc, 1'b1, acc);
        chk("post_rst_valid", 256'(out_valid), 256'(1));
        chk("post_rst_packet", out_packet, pack(pc));
        step(1'b0, idle, 1'b1, acc);
        chk("post_rst_empty", 256'(out_valid), 256'(0));

`ifdef UMI_PACK_BUF_STATS_EN
        nreset = 1'b0;
        #1;
        exp_q.delete();
        stall_prev = 1'b0;
        chk("cnt_reset", 256'(pkt_count), 256'(0));
        @(posedge clk);
        #1;
        nreset = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, rnd_fld(), 1'b1, acc);
        step(1'b0, idle, 1'b1, acc);
        chk("cnt_five", 256'(pkt_count), 256'(5));
        force dut.pkt_count = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count;
        step(1'b1, rnd_fld(), 1'b1, acc);
        step(1'b0, idle, 1'b1, acc);
        chk("cnt_wrap", 256'(pkt_count), 256'(0));
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
